ann_sequencer: RTL and testbench

ANN_SEQUENCER -- requirements
Module: ann_sequencer

---
 rtl/ann_pkg.sv | 50 +++++
 rtl/ann_idx_counter.sv | 38 +++
 rtl/ann_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 tb/tb_ann_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// ann_pkg: shared constants, the sequencer state encoding and the
// weight-address helper for the ANN training/inference sequencer.
//   ANN_N_IN / ANN_N_HID / ANN_N_OUT : default layer sizes
//   ANN_N_W                          : total weight count (hidden + output)
//   ANN_*_W                          : widths of the sequencer output fields
//   ann_state_e                      : FSM state encoding (IDLE must stay 0)
package ann_pkg;

    localparam int ANN_N_IN      = 30;
    localparam int ANN_N_HID     = 5;
    localparam int ANN_N_OUT     = 3;
    localparam int ANN_MAC_LAT   = 2;
    localparam int ANN_MAX_EPOCH = 100;
    localparam int ANN_N_W       = ANN_N_HID * ANN_N_IN + ANN_N_OUT * ANN_N_HID;

    localparam int ANN_ADDR_W  = 8;
    localparam int ANN_SEL_W   = 5;
    localparam int ANN_NRN_W   = 3;
    localparam int ANN_EPOCH_W = 10;
    localparam int ANN_STATE_W = 5;

    typedef enum logic [ANN_STATE_W-1:0] {
        S_IDLE    = 5'd0,
        S_L1_CLR  = 5'd1,
        S_L1_ACC  = 5'd2,
        S_L1_WAIT = 5'd3,
        S_L1_ACT  = 5'd4,
        S_L2_CLR  = 5'd5,
        S_L2_ACC  = 5'd6,
        S_L2_WAIT = 5'd7,
        S_L2_ACT  = 5'd8,
        S_BP_OUT  = 5'd9,
        S_BP_HID  = 5'd10,
        S_UPDATE  = 5'd11,
        S_DONE    = 5'd12,
        S_TDONE   = 5'd13
    } ann_state_e;

    // Weight address of operand idx of neuron nrn in a layer whose weights
    // start at base and occupy stride words per neuron.
    function automatic logic [ANN_ADDR_W-1:0] ann_weight_addr(
        input int                    base,
        input int                    stride,
        input logic [ANN_NRN_W-1:0]  nrn,
        input logic [ANN_ADDR_W-1:0] idx
    );
        return ANN_ADDR_W'(base) + ANN_ADDR_W'(stride) * ANN_ADDR_W'(nrn) + idx;
    endfunction

endpackage

// File: rtl/ann_idx_counter.sv
// ann_idx_counter: loadable up-counter with terminal-count flag.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_load_val (has priority over i_step)
//   i_step         : increment by one
//   i_max          : terminal value; o_tc is high while o_count == i_max
//   o_count        : current count (registered)
module ann_idx_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_step,
    input  logic [W-1:0] i_max,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    // Count register: load wins over step, otherwise hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= W'(0);
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_step) begin
            r_count <= r_count + W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_max);

endmodule

// File: rtl/ann_sequencer.sv
// ann_sequencer: control sequencer for a 2-layer neural network engine.
// Walks hidden then output layer (clear / accumulate / wait / activate per
// neuron); in training mode continues with backprop strobes and a full weight
// update sweep, repeating for MAX_EPOCH epochs.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_start, i_training     : run request and run type (sampled in IDLE only)
//   i_abort                 : synchronous cancel back to IDLE
//   o_mac_clr, o_mac_en     : MAC clear / accumulate strobes
//   o_in_sel, o_w_addr      : operand index and weight address
//   o_layer, o_neuron       : current layer (0 hidden, 1 output) and neuron
//   o_act_we, o_bp_en, o_wu_en : activation latch, backprop, weight update
//   o_busy, o_done, o_done_training, o_state, o_epoch_count : status
// All outputs are registered; they show the state of the previous cycle.
module ann_sequencer
    import ann_pkg::*;
#(
    parameter int N_IN      = ANN_N_IN,
    parameter int N_HID     = ANN_N_HID,
    parameter int N_OUT     = ANN_N_OUT,
    parameter int MAC_LAT   = ANN_MAC_LAT,
    parameter int MAX_EPOCH = ANN_MAX_EPOCH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_training,
    input  logic                   i_abort,
    output logic                   o_mac_clr,
    output logic                   o_mac_en,
    output logic [ANN_SEL_W-1:0]   o_in_sel,
    output logic [ANN_ADDR_W-1:0]  o_w_addr,
    output logic                   o_layer,
    output logic [ANN_NRN_W-1:0]   o_neuron,
    output logic                   o_act_we,
    output logic                   o_bp_en,
    output logic                   o_wu_en,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_done_training,
    output logic [ANN_STATE_W-1:0] o_state,
    output logic [ANN_EPOCH_W-1:0] o_epoch_count
);

    localparam int N_W = N_HID * N_IN + N_OUT * N_HID;

    ann_state_e             r_state;
    ann_state_e             w_next;
    logic                   r_mode;
    logic [ANN_EPOCH_W-1:0] r_epoch;

    logic                  w_idx_load, w_idx_step, w_idx_tc;
    logic [ANN_ADDR_W-1:0] w_idx, w_idx_max;
    logic                  w_nrn_load, w_nrn_step, w_nrn_tc;
    logic [ANN_NRN_W-1:0]  w_nrn, w_nrn_max;
    logic                  w_start, w_epoch_inc, w_kill;

    logic                   w_mac_clr, w_mac_en, w_layer, w_act_we, w_bp_en, w_wu_en;
    logic                   w_done, w_done_training;
    logic [ANN_SEL_W-1:0]   w_in_sel;
    logic [ANN_ADDR_W-1:0]  w_w_addr;
    logic [ANN_NRN_W-1:0]   w_neuron;

    logic                   r_mac_clr, r_mac_en, r_layer, r_act_we, r_bp_en, r_wu_en;
    logic                   r_busy, r_done, r_done_training;
    logic [ANN_SEL_W-1:0]   r_in_sel;
    logic [ANN_ADDR_W-1:0]  r_w_addr;
    logic [ANN_NRN_W-1:0]   r_neuron;
    logic [ANN_STATE_W-1:0] r_state_o;

    // Operand / per-state cycle index (also drives the update address sweep)
    ann_idx_counter #(.W(ANN_ADDR_W)) u_idx_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_idx_load),
        .i_load_val (ANN_ADDR_W'(0)),
        .i_step     (w_idx_step),
        .i_max      (w_idx_max),
        .o_count    (w_idx),
        .o_tc       (w_idx_tc)
    );

    // Neuron index within the current forward layer
    ann_idx_counter #(.W(ANN_NRN_W)) u_nrn_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_nrn_load),
        .i_load_val (ANN_NRN_W'(0)),
        .i_step     (w_nrn_step),
        .i_max      (w_nrn_max),
        .o_count    (w_nrn),
        .o_tc       (w_nrn_tc)
    );

    // Terminal values depend on state only, kept apart from next-state logic
    always_comb begin
        w_idx_max = ANN_ADDR_W'(0);
        w_nrn_max = ANN_NRN_W'(N_HID - 1);
        case (r_state)
            S_L1_ACC:             w_idx_max = ANN_ADDR_W'(N_IN - 1);
            S_L2_ACC:             w_idx_max = ANN_ADDR_W'(N_HID - 1);
            S_L1_WAIT, S_L2_WAIT: w_idx_max = ANN_ADDR_W'(MAC_LAT - 1);
            S_BP_OUT:             w_idx_max = ANN_ADDR_W'(N_OUT - 1);
            S_BP_HID:             w_idx_max = ANN_ADDR_W'(N_HID - 1);
            S_UPDATE:             w_idx_max = ANN_ADDR_W'(N_W - 1);
            default:              w_idx_max = ANN_ADDR_W'(0);
        endcase
        if (r_state == S_L2_ACT) begin
            w_nrn_max = ANN_NRN_W'(N_OUT - 1);
        end else begin
            w_nrn_max = ANN_NRN_W'(N_HID - 1);
        end
    end

    // Next-state and counter control
    always_comb begin
        w_next      = r_state;
        w_idx_load  = 1'b0;
        w_idx_step  = 1'b0;
        w_nrn_load  = 1'b0;
        w_nrn_step  = 1'b0;
        w_start     = 1'b0;
        w_epoch_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_next     = S_L1_CLR;
                    w_start    = 1'b1;
                    w_idx_load = 1'b1;
                    w_nrn_load = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_L1_CLR, S_L2_CLR: begin
                w_next     = (r_state == S_L1_CLR) ? S_L1_ACC : S_L2_ACC;
                w_idx_load = 1'b1;
            end
            S_L1_ACC, S_L2_ACC: begin
                if (w_idx_tc) begin
                    w_next     = (r_state == S_L1_ACC) ? S_L1_WAIT : S_L2_WAIT;
                    w_idx_load = 1'b1;
                end else begin
                    w_idx_step = 1'b1;
                end
            end
            S_L1_WAIT, S_L2_WAIT: begin
                if (w_idx_tc) begin
                    w_next     = (r_state == S_L1_WAIT) ? S_L1_ACT : S_L2_ACT;
                    w_idx_load = 1'b1;
                end else begin
                    w_idx_step = 1'b1;
                end
            end
            S_L1_ACT: begin
                if (w_nrn_tc) begin
                    w_next     = S_L2_CLR;
                    w_nrn_load = 1'b1;
                end else begin
                    w_next     = S_L1_CLR;
                    w_nrn_step = 1'b1;
                end
            end
            S_L2_ACT: begin
                if (w_nrn_tc) begin
                    w_next     = r_mode ? S_BP_OUT : S_DONE;
                    w_nrn_load = 1'b1;
                    w_idx_load = 1'b1;
                end else begin
                    w_next     = S_L2_CLR;
                    w_nrn_step = 1'b1;
                end
            end
            S_BP_OUT, S_BP_HID: begin
                if (w_idx_tc) begin
                    w_next     = (r_state == S_BP_OUT) ? S_BP_HID : S_UPDATE;
                    w_idx_load = 1'b1;
                end else begin
                    w_idx_step = 1'b1;
                end
            end
            S_UPDATE: begin
                if (w_idx_tc) begin
                    w_idx_load  = 1'b1;
                    w_nrn_load  = 1'b1;
                    w_epoch_inc = 1'b1;
                    if ((r_epoch + ANN_EPOCH_W'(1)) == ANN_EPOCH_W'(MAX_EPOCH)) begin
                        w_next = S_TDONE;
                    end else begin
                        w_next = S_L1_CLR;
                    end
                end else begin
                    w_idx_step = 1'b1;
                end
            end
            S_DONE, S_TDONE: w_next = S_IDLE;
            default:         w_next = S_IDLE;
        endcase
        // Abort overrides everything outside IDLE and must not count the epoch
        if (w_kill) begin
            w_next      = S_IDLE;
            w_epoch_inc = 1'b0;
        end else begin
            w_next = w_next;
        end
    end

    assign w_kill = i_abort && (r_state != S_IDLE);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Run mode and epoch counter; epoch holds on abort and after TDONE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode  <= 1'b0;
            r_epoch <= ANN_EPOCH_W'(0);
        end else if (w_start) begin
            r_mode  <= i_training;
            r_epoch <= ANN_EPOCH_W'(0);
        end else if (w_epoch_inc) begin
            r_epoch <= r_epoch + ANN_EPOCH_W'(1);
        end else begin
            r_epoch <= r_epoch;
        end
    end

    // Moore output decode of the current state
    always_comb begin
        w_mac_clr       = 1'b0;
        w_mac_en        = 1'b0;
        w_act_we        = 1'b0;
        w_bp_en         = 1'b0;
        w_wu_en         = 1'b0;
        w_done          = 1'b0;
        w_done_training = 1'b0;
        w_layer         = 1'b0;
        w_neuron        = ANN_NRN_W'(0);
        w_in_sel        = ANN_SEL_W'(0);
        w_w_addr        = ANN_ADDR_W'(0);
        case (r_state)
            S_IDLE: w_layer = 1'b0;
            S_L1_CLR: begin
                w_mac_clr = 1'b1;
                w_neuron  = w_nrn;
            end
            S_L1_ACC: begin
                w_mac_en = 1'b1;
                w_neuron = w_nrn;
                w_in_sel = w_idx[ANN_SEL_W-1:0];
                w_w_addr = ann_weight_addr(0, N_IN, w_nrn, w_idx);
            end
            S_L1_WAIT: w_neuron = w_nrn;
            S_L1_ACT: begin
                w_act_we = 1'b1;
                w_neuron = w_nrn;
            end
            S_L2_CLR: begin
                w_mac_clr = 1'b1;
                w_layer   = 1'b1;
                w_neuron  = w_nrn;
            end
            S_L2_ACC: begin
                w_mac_en = 1'b1;
                w_layer  = 1'b1;
                w_neuron = w_nrn;
                w_in_sel = w_idx[ANN_SEL_W-1:0];
                w_w_addr = ann_weight_addr(N_HID * N_IN, N_HID, w_nrn, w_idx);
            end
            S_L2_WAIT: begin
                w_layer  = 1'b1;
                w_neuron = w_nrn;
            end
            S_L2_ACT: begin
                w_act_we = 1'b1;
                w_layer  = 1'b1;
                w_neuron = w_nrn;
            end
            S_BP_OUT: begin
                w_bp_en  = 1'b1;
                w_layer  = 1'b1;
                w_neuron = w_idx[ANN_NRN_W-1:0];
            end
            S_BP_HID: begin
                w_bp_en  = 1'b1;
                w_neuron = w_idx[ANN_NRN_W-1:0];
            end
            S_UPDATE: begin
                w_wu_en  = 1'b1;
                w_w_addr = w_idx;
            end
            S_DONE: w_done = 1'b1;
            S_TDONE: begin
                w_done          = 1'b1;
                w_done_training = 1'b1;
            end
            default: w_layer = 1'b0;
        endcase
    end

    // Output register; an abort suppresses the pending outputs (no done pulse)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mac_clr       <= 1'b0;
            r_mac_en        <= 1'b0;
            r_act_we        <= 1'b0;
            r_bp_en         <= 1'b0;
            r_wu_en         <= 1'b0;
            r_done          <= 1'b0;
            r_done_training <= 1'b0;
            r_busy          <= 1'b0;
            r_layer         <= 1'b0;
            r_neuron        <= ANN_NRN_W'(0);
            r_in_sel        <= ANN_SEL_W'(0);
            r_w_addr        <= ANN_ADDR_W'(0);
            r_state_o       <= ANN_STATE_W'(0);
        end else if (w_kill) begin
            r_mac_clr       <= 1'b0;
            r_mac_en        <= 1'b0;
            r_act_we        <= 1'b0;
            r_bp_en         <= 1'b0;
            r_wu_en         <= 1'b0;
            r_done          <= 1'b0;
            r_done_training <= 1'b0;
            r_busy          <= 1'b0;
            r_layer         <= 1'b0;
            r_neuron        <= ANN_NRN_W'(0);
            r_in_sel        <= ANN_SEL_W'(0);
            r_w_addr        <= ANN_ADDR_W'(0);
            r_state_o       <= ANN_STATE_W'(0);
        end else begin
            r_mac_clr       <= w_mac_clr;
            r_mac_en        <= w_mac_en;
            r_act_we        <= w_act_we;
            r_bp_en         <= w_bp_en;
            r_wu_en         <= w_wu_en;
            r_done          <= w_done;
            r_done_training <= w_done_training;
            r_busy          <= (r_state != S_IDLE);
            r_layer         <= w_layer;
            r_neuron        <= w_neuron;
            r_in_sel        <= w_in_sel;
            r_w_addr        <= w_w_addr;
            r_state_o       <= r_state;
        end
    end

    assign o_mac_clr       = r_mac_clr;
    assign o_mac_en        = r_mac_en;
    assign o_in_sel        = r_in_sel;
    assign o_w_addr        = r_w_addr;
    assign o_layer         = r_layer;
    assign o_neuron        = r_neuron;
    assign o_act_we        = r_act_we;
    assign o_bp_en         = r_bp_en;
    assign o_wu_en         = r_wu_en;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_done_training = r_done_training;
    assign o_state         = r_state_o;
    assign o_epoch_count   = r_epoch;

endmodule

// File: tb/tb_ann_sequencer.sv
// tb_ann_sequencer: directed bench for ann_sequencer (MAX_EPOCH = 2).
// Expected strobe events (cycle, kind, layer, neuron, in_sel, w_addr) are
// queued when a run is started and popped as the DUT emits them. Cycle 0 is
// the clock edge that samples Start.
module tb_ann_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, training, abort;
    logic       mac_clr, mac_en, layer, act_we, bp_en, wu_en, busy, done, done_training;
    logic [4:0] in_sel;
    logic [7:0] w_addr;
    logic [2:0] neuron;
    logic [4:0] state;
    logic [9:0] epoch;

    int n_assert = 0;
    int n_fail   = 0;
    int push_lim = 1000000;

    typedef struct {int cyc; int val;} ep_chk_t;
    logic [35:0] evq[$];
    ep_chk_t     epq[$];

    always #5 clk = ~clk;

    ann_sequencer #(.MAX_EPOCH(2)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_training      (training),
        .i_abort         (abort),
        .o_mac_clr       (mac_clr),
        .o_mac_en        (mac_en),
        .o_in_sel        (in_sel),
        .o_w_addr        (w_addr),
        .o_layer         (layer),
        .o_neuron        (neuron),
        .o_act_we        (act_we),
        .o_bp_en         (bp_en),
        .o_wu_en         (wu_en),
        .o_busy          (busy),
        .o_done          (done),
        .o_done_training (done_training),
        .o_state         (state),
        .o_epoch_count   (epoch)
    );

    wire [39:0] all_out = {mac_clr, mac_en, in_sel, w_addr, layer, neuron, act_we,
                           bp_en, wu_en, busy, done, done_training, state, epoch};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // kind: 1 clr, 2 acc, 3 act, 4 bp, 5 wu, 6 done, 7 done+doneTraining, 0 illegal
    function automatic logic [35:0] mk_ev(int c, int k, int ly, int nr, int is, int ad);
        return {16'(c), 3'(k), 1'(ly), 3'(nr), 5'(is), 8'(ad)};
    endfunction

    task automatic push_ev(int c, int k, int ly, int nr, int is, int ad);
        if (c <= push_lim) evq.push_back(mk_ev(c, k, ly, nr, is, ad));
    endtask

    // Forward pass: 5 hidden neurons x 34 cycles, 3 output neurons x 9 cycles
    task automatic push_layers(input int b);
        for (int h = 0; h < 5; h++) begin
            int c0;
            c0 = b + 1 + 34 * h;
            push_ev(c0, 1, 0, h, 0, 0);
            for (int i = 0; i < 30; i++) push_ev(c0 + 1 + i, 2, 0, h, i, h * 30 + i);
            push_ev(c0 + 33, 3, 0, h, 0, 0);
        end
        for (int m = 0; m < 3; m++) begin
            int c0;
            c0 = b + 171 + 9 * m;
            push_ev(c0, 1, 1, m, 0, 0);
            for (int j = 0; j < 5; j++) push_ev(c0 + 1 + j, 2, 1, m, j, 150 + m * 5 + j);
            push_ev(c0 + 8, 3, 1, m, 0, 0);
        end
    endtask

    task automatic push_epoch(input int b);
        push_layers(b);
        for (int k = 0; k < 3; k++)   push_ev(b + 198 + k, 4, 1, k, 0, 0);
        for (int k = 0; k < 5; k++)   push_ev(b + 201 + k, 4, 0, k, 0, 0);
        for (int a = 0; a < 165; a++) push_ev(b + 206 + a, 5, 0, 0, 0, a);
    endtask

    // Runs ncyc cycles from the Start-sampling edge, comparing events and
    // applying the optional busy-Start, abort, restart and reset injections.
    task automatic monitor(input int ncyc, input logic train, input int busy_inj,
                           input int abort_cyc, input int restart_cyc, input int rst_cyc);
        int          sc, k;
        logic [35:0] ev;
        ep_chk_t     e;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            sc = int'(mac_clr) + int'(mac_en) + int'(act_we) + int'(bp_en) + int'(wu_en)
               + int'(done) + int'(done_training && !done);
            if (sc > 1)                  k = 0;
            else if (mac_clr)            k = 1;
            else if (mac_en)             k = 2;
            else if (act_we)             k = 3;
            else if (bp_en)              k = 4;
            else if (wu_en)              k = 5;
            else if (done && done_training) k = 7;
            else if (done)               k = 6;
            else                         k = 0;
            case (k)
                1, 3, 4: ev = mk_ev(c, k, int'(layer), int'(neuron), 0, 0);
                2:       ev = mk_ev(c, k, int'(layer), int'(neuron), int'(in_sel), int'(w_addr));
                5:       ev = mk_ev(c, k, 0, 0, 0, int'(w_addr));
                6, 7:    ev = mk_ev(c, k, 0, 0, 0, 0);
                default: ev = mk_ev(c, 0, int'(layer), int'(neuron), int'(in_sel), int'(w_addr));
            endcase
            if (sc > 0) begin
                if (evq.size() == 0) chk("unexpected_event", 64'(ev), {64{1'b1}});
                else                 chk("event", 64'(ev), 64'(evq.pop_front()));
            end
            if (epq.size() > 0 && epq[0].cyc == c) begin
                e = epq.pop_front();
                chk("epoch_count", 64'(epoch), 64'(e.val));
            end
            if (abort_cyc >= 0 && c == abort_cyc + 1) begin
                chk("abort_state", 64'(state), 64'(0));
                chk("abort_busy", 64'(busy), 64'(0));
            end
            start    = (c == busy_inj) || (c == restart_cyc);
            training = (c == busy_inj) ? 1'b1 : train;
            abort    = (c == abort_cyc);
            if (c == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                chk("async_reset_outputs", 64'(all_out), 64'(0));
                #1;
                rst_n = 1'b1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        chk("queue_drained", 64'(evq.size()), 64'(0));
        chk("epoch_checks_drained", 64'(epq.size()), 64'(0));
        chk("end_state_idle", 64'(state), 64'(0));
        chk("end_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        training = 1'b0;
        abort    = 1'b0;
        #12;
        chk("reset_outputs", 64'(all_out), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("idle_after_reset", 64'(all_out), 64'(0));

        // Inference run, with a Start/training pulse while busy at cycle 20
        push_lim = 1000000;
        push_layers(0);
        push_ev(198, 6, 0, 0, 0, 0);
        start    = 1'b1;
        training = 1'b0;
        monitor(205, 1'b0, 20, -1, -1, -1);
        chk("inference_epoch", 64'(epoch), 64'(0));

        // Training run, two epochs
        push_epoch(0);
        push_epoch(370);
        push_ev(741, 7, 0, 0, 0, 0);
        epq.push_back('{369, 0});
        epq.push_back('{370, 1});
        epq.push_back('{739, 1});
        epq.push_back('{740, 2});
        epq.push_back('{741, 2});
        start    = 1'b1;
        training = 1'b1;
        monitor(750, 1'b1, -1, -1, -1, -1);
        chk("epoch_held_after_tdone", 64'(epoch), 64'(2));

        // Abort at cycle 50, restart sampled at cycle 60
        push_lim = 50;
        push_layers(0);
        push_lim = 1000000;
        push_layers(60);
        push_ev(258, 6, 0, 0, 0, 0);
        start    = 1'b1;
        training = 1'b0;
        monitor(265, 1'b0, -1, 50, 59, -1);

        // Reset mid hidden layer at cycle 100; nothing may follow
        push_lim = 100;
        push_layers(0);
        start    = 1'b1;
        training = 1'b0;
        monitor(130, 1'b0, -1, -1, -1, 100);
        chk("epoch_after_reset", 64'(epoch), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
